pipe_hazard_scoreboard: RTL

//  Parametrised hazard/forwarding controller for the pipelined CPU: a DEPTH-entry shift-register scoreboard of in-flight writers
//  (stage 0 = EX, stage DEPTH-1 = WB). Generates load-use stall, per-operand forwarding selects for the EX instruction, applies

---
 rtl/pipe_hazard_scoreboard.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller: DEPTH-stage shift-register scoreboard of
// in-flight writers (stage 0 = EX, stage DEPTH-1 = WB). Produces load-use
// stall, per-operand forwarding selects for EX, applies branch flushes to
// its own entries and keeps saturating stall/flush counters.
module pipe_hazard_scoreboard #(
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned AW          = 5,
    parameter int unsigned LOAD_STAGE  = 1,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned CW          = 16,
    localparam int unsigned FW         = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [AW-1:0]    id_rs_i,
    input  logic [AW-1:0]    id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [AW-1:0]    id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [FW-1:0]    fwd_a_o,
    output logic [FW-1:0]    fwd_b_o,
    output logic [DEPTH-1:0] stg_valid_o,
    output logic [CW-1:0]    stall_cnt_o,
    output logic [CW-1:0]    flush_cnt_o
);

    // The load flag only matters in stages whose result is not yet available,
    // so it is carried through stages 0..LOAD_STAGE-1 only.
    localparam int unsigned MW = (LOAD_STAGE > 0) ? LOAD_STAGE : 1;

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0]         regwrite_q, regwrite_d;
    logic [MW-1:0]            memread_q, memread_d;
    logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
    logic [AW-1:0]            rs_q, rs_d;
    logic [AW-1:0]            rt_q, rt_d;
    logic                     use_rs_q, use_rs_d;
    logic                     use_rt_q, use_rt_d;
    logic [CW-1:0]            stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]            flush_cnt_q, flush_cnt_d;

    logic                     stall;
    logic [DEPTH-1:1]         ex_a_hit;
    logic [DEPTH-1:1]         ex_b_hit;

    // Load-use detection against the ID instruction; a flush wins over a stall.
    always_comb begin
        stall = 1'b0;
        for (int unsigned k = 0; k < LOAD_STAGE; k++) begin
            if (valid_q[k] && regwrite_q[k] && memread_q[k] && (rd_q[k] != '0) &&
                ((id_use_rs_i && (rd_q[k] == id_rs_i)) ||
                 (id_use_rt_i && (rd_q[k] == id_rt_i)))) begin
                stall = 1'b1;
            end
        end
        stall = stall && id_valid_i && !flush_i;
    end

    // Forwarding selects for the EX instruction; youngest matching producer wins.
    always_comb begin
        ex_a_hit = '0;
        ex_b_hit = '0;
        fwd_a_o  = '0;
        fwd_b_o  = '0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            ex_a_hit[k] = valid_q[0] && use_rs_q && valid_q[k] && regwrite_q[k] &&
                          (rd_q[k] != '0) && (rd_q[k] == rs_q);
            ex_b_hit[k] = valid_q[0] && use_rt_q && valid_q[k] && regwrite_q[k] &&
                          (rd_q[k] != '0) && (rd_q[k] == rt_q);
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (ex_a_hit[k] && (fwd_a_o == '0)) fwd_a_o = FW'(k);
            if (ex_b_hit[k] && (fwd_b_o == '0)) fwd_b_o = FW'(k);
        end
    end

    // Next scoreboard contents: shift one stage, load ID or a bubble into stage 0.
    always_comb begin
        valid_d    = '0;
        regwrite_d = '0;
        memread_d  = '0;
        rd_d       = '0;
        valid_d[0]    = id_valid_i && !stall && !flush_i;
        regwrite_d[0] = id_regwrite_i;
        memread_d[0]  = id_memread_i;
        rd_d[0]       = id_rd_i;
        rs_d          = id_rs_i;
        rt_d          = id_rt_i;
        use_rs_d      = id_use_rs_i;
        use_rt_d      = id_use_rt_i;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            // old stage k-1 is killed by a flush when k-1 < FLUSH_DEPTH
            valid_d[k]    = valid_q[k-1] && !(flush_i && (k <= FLUSH_DEPTH));
            regwrite_d[k] = regwrite_q[k-1];
            rd_d[k]       = rd_q[k-1];
        end
        for (int unsigned k = 1; k < MW; k++) begin
            memread_d[k] = memread_q[k-1];
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
        if (flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CW'(1);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            regwrite_q  <= '0;
            memread_q   <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            use_rs_q    <= 1'b0;
            use_rt_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memread_q   <= memread_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            use_rs_q    <= use_rs_d;
            use_rt_q    <= use_rt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_o     = stall;
    assign stg_valid_o = valid_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
